// File: rtl/uart_rx_pkg.sv
// Shared constants, FSM encoding and helpers for the debug-link UART receiver.
// Bit timing matches uart_tx: one bit lasts DIVISOR+1 clock cycles.
package uart_rx_pkg;

   localparam int CNT_W = 9;

   localparam logic [CNT_W-1:0] DIVISOR  = 9'd286;
   localparam logic [CNT_W-1:0] HALF_BIT = 9'd143;
   // The vote is complete one cycle after the centre sample.
   localparam logic [CNT_W-1:0] MID_DECIDE = HALF_BIT + 9'd1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } rx_state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte handshake between the receiver and the LPC-side consumer.
// valid/ack: rx_data is stable while rx_data_valid=1; one sampled ack retires it.
interface uart_rx_if;
   logic [7:0] rx_data;
   logic       rx_data_valid;
   logic       rx_data_ack;
   logic       framing_err;
   logic       overrun;
   logic       busy;

   modport master (
      output rx_data, rx_data_valid, framing_err, overrun, busy,
      input  rx_data_ack
   );

   modport slave (
      input  rx_data, rx_data_valid, framing_err, overrun, busy,
      output rx_data_ack
   );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser with a history flop for edge detection,
// plus the 2-of-3 mid-bit voter.
module uart_rx_sync
   import uart_rx_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             rx,
   input  logic [CNT_W-1:0] cnt,
   output logic             line,
   output logic             fall_edge,
   output logic             vote
);

   logic s1, s2, s3;
   logic smp_a, smp_b;

   // Reset low so a line held low through reset never looks like a start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         s3    <= 1'b0;
         smp_a <= 1'b0;
         smp_b <= 1'b0;
      end else begin
         s1 <= rx;
         s2 <= s1;
         s3 <= s2;
         if (cnt == HALF_BIT - 9'd1) smp_a <= s2;
         if (cnt == HALF_BIT)        smp_b <= s2;
      end
   end

   assign line      = s2;
   assign fall_edge = s3 & ~s2;
   assign vote      = maj3(smp_a, smp_b, s2);

endmodule

// File: rtl/uart_rx.sv
// 8-N-1 UART receiver with a one-deep holding register and valid/ack handshake.
// The byte commits at the stop-bit mid-point so back-to-back frames are accepted.
module uart_rx
   import uart_rx_pkg::*;
(
   input  logic       lpc_clk,
   input  logic       lpc_rst,
   input  logic       rx,
   uart_rx_if.master  host,
   output rx_state_t  fsm_state
);

   logic             line, fall_edge, vote;
   rx_state_t        st;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       idx;
   logic [7:0]       shreg;
   logic [7:0]       data_q;
   logic             valid_q, ferr_q, ovr_q, busy_q;

   uart_rx_sync u_sync (
      .clk       (lpc_clk),
      .rst       (lpc_rst),
      .rx        (rx),
      .cnt       (cnt),
      .line      (line),
      .fall_edge (fall_edge),
      .vote      (vote)
   );

   always_ff @(posedge lpc_clk or posedge lpc_rst) begin
      if (lpc_rst) begin
         st      <= S_IDLE;
         cnt     <= '0;
         idx     <= '0;
         shreg   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         ferr_q <= 1'b0;
         ovr_q  <= 1'b0;
         cnt    <= cnt + 9'd1;
         if (host.rx_data_ack && valid_q) valid_q <= 1'b0;

         case (st)
            S_IDLE: begin
               cnt <= '0;
               if (fall_edge) begin
                  st     <= S_START;
                  busy_q <= 1'b1;
               end
            end
            S_START: begin
               if (cnt == MID_DECIDE && vote) begin
                  st     <= S_IDLE;
                  cnt    <= '0;
                  busy_q <= 1'b0;
               end else if (cnt == DIVISOR) begin
                  st  <= S_DATA;
                  cnt <= '0;
                  idx <= '0;
               end
            end
            S_DATA: begin
               if (cnt == MID_DECIDE) shreg <= {vote, shreg[7:1]};
               if (cnt == DIVISOR) begin
                  cnt <= '0;
                  if (idx == 3'd7) st <= S_STOP;
                  else             idx <= idx + 3'd1;
               end
            end
            S_STOP: begin
               if (cnt == MID_DECIDE) begin
                  cnt <= '0;
                  if (vote) begin
                     st     <= S_IDLE;
                     busy_q <= 1'b0;
                     // A same-cycle ack frees the register for the new byte.
                     if (!valid_q || host.rx_data_ack) begin
                        data_q  <= shreg;
                        valid_q <= 1'b1;
                     end else begin
                        ovr_q <= 1'b1;
                     end
                  end else begin
                     st     <= S_BREAK;
                     ferr_q <= 1'b1;
                  end
               end
            end
            S_BREAK: begin
               cnt <= '0;
               if (line) begin
                  st     <= S_IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               st     <= S_IDLE;
               cnt    <= '0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign host.rx_data       = data_q;
   assign host.rx_data_valid = valid_q;
   assign host.framing_err   = ferr_q;
   assign host.overrun       = ovr_q;
   assign host.busy          = busy_q;
   assign fsm_state          = st;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives serial frames, scoreboards received bytes,
// and checks error pulses, busy and the holding-register handshake.
module tb_uart_rx;
   import uart_rx_pkg::*;

   localparam int T = 287;

   logic      lpc_clk = 1'b0;
   logic      lpc_rst;
   logic      rx;
   rx_state_t fsm_state;
   uart_rx_if rif();

   uart_rx dut (
      .lpc_clk   (lpc_clk),
      .lpc_rst   (lpc_rst),
      .rx        (rx),
      .host      (rif),
      .fsm_state (fsm_state)
   );

   always #5 lpc_clk = ~lpc_clk;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];
   int commit_cnt = 0;
   int ferr_cnt   = 0;
   int ovr_cnt    = 0;
   logic [7:0] held = 8'h00;
   logic pv = 1'b0;
   logic pa = 1'b0;
   logic auto_ack = 1'b0;
   int   ack_wait = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Pre-edge valid/ack, used to recognise a newly presented byte.
   always @(posedge lpc_clk) begin
      pv <= rif.rx_data_valid;
      pa <= rif.rx_data_ack;
   end

   always @(negedge lpc_clk) begin
      if (!lpc_rst) begin
         if (rif.framing_err) ferr_cnt++;
         if (rif.overrun)     ovr_cnt++;
         if (rif.framing_err || rif.overrun)
            check("err_exclusive", 32'(rif.framing_err & rif.overrun), 32'd0);
         if (rif.rx_data_valid && (!pv || pa)) begin
            commit_cnt++;
            check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("byte_value", 32'(rif.rx_data), 32'(exp_q.pop_front()));
            held = rif.rx_data;
         end else if (rif.rx_data_valid && pv && !pa) begin
            check("data_stable", 32'(rif.rx_data), 32'(held));
         end
      end
   end

   always @(negedge lpc_clk) begin
      if (auto_ack) begin
         if (rif.rx_data_valid && !rif.rx_data_ack) begin
            if (ack_wait == 4) begin
               rif.rx_data_ack = 1'b1;
               ack_wait = 0;
            end else ack_wait++;
         end else begin
            rif.rx_data_ack = 1'b0;
            ack_wait = 0;
         end
      end
   end

   task automatic send_bit(input logic b, input int period);
      rx = b;
      repeat (period) @(negedge lpc_clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input int period, input logic stop_bit);
      send_bit(1'b0, period);
      for (int i = 0; i < 8; i++) send_bit(b[i], period);
      send_bit(stop_bit, period);
   endtask

   initial begin
      int c0, f0, o0, drop_at;
      logic seen, found;
      lpc_rst = 1'b1;
      rx = 1'b1;
      rif.rx_data_ack = 1'b0;
      repeat (3) @(negedge lpc_clk);
      check("rst_data",  32'(rif.rx_data), 32'h00);
      check("rst_valid", 32'(rif.rx_data_valid), 32'd0);
      check("rst_ferr",  32'(rif.framing_err), 32'd0);
      check("rst_ovr",   32'(rif.overrun), 32'd0);
      check("rst_busy",  32'(rif.busy), 32'd0);
      check("rst_state", 32'(fsm_state), 32'(S_IDLE));
      lpc_rst = 1'b0;
      repeat (10) @(negedge lpc_clk);

      // Back-to-back frames with auto ack.
      auto_ack = 1'b1;
      c0 = commit_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
      exp_q.push_back(8'h55);
      exp_q.push_back(8'hA3);
      send_frame(8'h55, T, 1'b1);
      send_frame(8'hA3, T, 1'b1);
      repeat (20) @(negedge lpc_clk);
      check("t1_commits", 32'(commit_cnt - c0), 32'd2);
      check("t1_queue",   32'(exp_q.size()), 32'd0);
      check("t1_ferr",    32'(ferr_cnt - f0), 32'd0);
      check("t1_ovr",     32'(ovr_cnt - o0), 32'd0);
      check("t1_valid",   32'(rif.rx_data_valid), 32'd0);
      check("t1_data",    32'(rif.rx_data), 32'hA3);

      // Short low glitch: aborts in START at the start-bit mid-point.
      c0 = commit_cnt;
      drop_at = -1; seen = 1'b0;
      rx = 1'b0;
      for (int i = 1; i <= 400; i++) begin
         @(negedge lpc_clk);
         if (i == 100) rx = 1'b1;
         if (rif.busy) seen = 1'b1;
         else if (seen && drop_at < 0) drop_at = i;
      end
      check("t2_busy_rose",   32'(seen), 32'd1);
      check("t2_busy_window", 32'(drop_at >= 140 && drop_at <= 155), 32'd1);
      check("t2_commits",     32'(commit_cnt - c0), 32'd0);
      check("t2_state",       32'(fsm_state), 32'(S_IDLE));

      // Bad stop bit followed by a held-low line, then a good frame.
      c0 = commit_cnt; f0 = ferr_cnt;
      send_frame(8'h3C, T, 1'b0);
      send_bit(1'b0, 5 * T);
      check("t3_busy_held", 32'(rif.busy), 32'd1);
      check("t3_in_break",  32'(fsm_state), 32'(S_BREAK));
      rx = 1'b1;
      repeat (6) @(negedge lpc_clk);
      check("t3_busy_low",  32'(rif.busy), 32'd0);
      check("t3_idle",      32'(fsm_state), 32'(S_IDLE));
      check("t3_ferr",      32'(ferr_cnt - f0), 32'd1);
      check("t3_no_commit", 32'(commit_cnt - c0), 32'd0);
      exp_q.push_back(8'h81);
      send_frame(8'h81, T, 1'b1);
      repeat (20) @(negedge lpc_clk);
      check("t3_commit_81", 32'(commit_cnt - c0), 32'd1);
      check("t3_queue",     32'(exp_q.size()), 32'd0);
      check("t3_ferr_once", 32'(ferr_cnt - f0), 32'd1);

      // Second byte while unacked: overrun, first byte kept.
      auto_ack = 1'b0;
      c0 = commit_cnt; o0 = ovr_cnt;
      exp_q.push_back(8'h11);
      send_frame(8'h11, T, 1'b1);
      send_frame(8'h22, T, 1'b1);
      repeat (20) @(negedge lpc_clk);
      check("t4_ovr",     32'(ovr_cnt - o0), 32'd1);
      check("t4_data",    32'(rif.rx_data), 32'h11);
      check("t4_valid",   32'(rif.rx_data_valid), 32'd1);
      check("t4_commits", 32'(commit_cnt - c0), 32'd1);
      rif.rx_data_ack = 1'b1;
      @(negedge lpc_clk);
      rif.rx_data_ack = 1'b0;
      @(negedge lpc_clk);
      check("t4_ack_clears", 32'(rif.rx_data_valid), 32'd0);
      check("t4_data_kept",  32'(rif.rx_data), 32'h11);

      // Ack lands exactly on the commit edge of the next byte.
      exp_q.push_back(8'h66);
      send_frame(8'h66, T, 1'b1);
      exp_q.push_back(8'h77);
      o0 = ovr_cnt;
      found = 1'b0;
      fork
         send_frame(8'h77, T, 1'b1);
         begin
            for (int i = 0; i < 12 * T && !found; i++) begin
               @(negedge lpc_clk);
               if (fsm_state == S_STOP) found = 1'b1;
            end
            if (found) begin
               repeat (144) @(negedge lpc_clk);
               rif.rx_data_ack = 1'b1;
               @(negedge lpc_clk);
               rif.rx_data_ack = 1'b0;
            end
         end
      join
      check("t5_stop_seen", 32'(found), 32'd1);
      check("t5_data",      32'(rif.rx_data), 32'h77);
      check("t5_valid",     32'(rif.rx_data_valid), 32'd1);
      check("t5_no_ovr",    32'(ovr_cnt - o0), 32'd0);
      check("t5_queue",     32'(exp_q.size()), 32'd0);
      rif.rx_data_ack = 1'b1;
      @(negedge lpc_clk);
      rif.rx_data_ack = 1'b0;
      repeat (2) @(negedge lpc_clk);

      // Reset in the middle of data bit 4, then frames at +/-2% baud.
      c0 = commit_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
      send_bit(1'b0, T);
      for (int i = 0; i < 4; i++) send_bit(i[0], T);
      send_bit(1'b1, 140);
      lpc_rst = 1'b1;
      rx = 1'b1;
      @(negedge lpc_clk);
      check("t6_rst_data",  32'(rif.rx_data), 32'h00);
      check("t6_rst_valid", 32'(rif.rx_data_valid), 32'd0);
      check("t6_rst_busy",  32'(rif.busy), 32'd0);
      check("t6_rst_state", 32'(fsm_state), 32'(S_IDLE));
      check("t6_rst_ferr",  32'(rif.framing_err), 32'd0);
      check("t6_rst_ovr",   32'(rif.overrun), 32'd0);
      @(negedge lpc_clk);
      lpc_rst = 1'b0;
      repeat (300) @(negedge lpc_clk);
      check("t6_no_pulses", 32'((ferr_cnt - f0) + (ovr_cnt - o0)), 32'd0);
      check("t6_no_commit", 32'(commit_cnt - c0), 32'd0);
      auto_ack = 1'b1;
      exp_q.push_back(8'hE5);
      exp_q.push_back(8'hE5);
      send_frame(8'hE5, 281, 1'b1);
      send_frame(8'hE5, 293, 1'b1);
      repeat (20) @(negedge lpc_clk);
      check("t6_commits", 32'(commit_cnt - c0), 32'd2);
      check("t6_queue",   32'(exp_q.size()), 32'd0);
      check("t6_data",    32'(rif.rx_data), 32'hE5);
      check("t6_errs",    32'((ferr_cnt - f0) + (ovr_cnt - o0)), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
